imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer-side front end for the instruction memory write port (`add`/`data`/`write`).
- Accepts a byte stream from a host link (e.g. a UART receiver) and assembles big-endian 32-bit instruction words.
- Drives one write per word at consecutive addresses, and holds the CPU until the program image is fully loaded.
- Sits between the host-link receiver and `instruction_mem`; the `pc`/`inst` read path is untouched.

Parameters:
- BASE_ADDR, 32'h0000_0000, address of the first word written.
- ADDR_STEP, 1, address increment per word (1 = word-addressed memory, 4 = byte-addressed).
- MAX_WORDS, 256, largest accepted image length in words.
- WRITE_CYCLES, 1, cycles `write` is held high per word (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load when not busy.
- byte_in  input  8  stream byte.
- byte_valid  input  1  byte_in valid.
- byte_ready  output  1  loader can accept a byte this cycle.
- add  output  32  instruction memory write address.
- data  output  32  instruction memory write data.
- write  output  1  instruction memory write enable.
- busy  output  1  load in progress.
- done  output  1  image fully written; held until next start.
- err  output  1  load aborted or corrupt; held until next start.
- cpu_hold  output  1  keep CPU/PC in reset while high.
- words_written  output  16  count of words written in the current load.

Behaviour:
- Reset (async) values: add=0, data=0, write=0, byte_ready=0, busy=0, done=0, err=0, cpu_hold=1, words_written=0; state=IDLE.
- Handshake: a byte is consumed on a rising edge where byte_valid && byte_ready. Bytes are never buffered when byte_ready=0.
- IDLE: byte_ready=0. start -> LEN; clear done, err, words_written and the byte counter.
- LEN: byte_ready=1. Shift 4 bytes MSB-first into N.
  - On the 4th byte: N==0 -> DONE; N>MAX_WORDS -> ERR; else -> DATA.
- DATA: byte_ready=1. Shift 4 bytes MSB-first into the assembly register.
  - On the 4th byte, register data<=word and add<=BASE_ADDR+idx*ADDR_STEP (32-bit, wraps mod 2^32), then -> WRITE.
- WRITE: byte_ready=0; write=1 for exactly WRITE_CYCLES cycles. add and data stay stable for the whole pulse and afterwards until the next word.
  - After the pulse: idx++, words_written++.
  - If idx==N -> DONE (or CSUM when enabled); else -> DATA.
  - First write asserts 1 cycle after the 4th byte of word 0 is consumed.
- DONE: done=1, cpu_hold=0, byte_ready=0.
- ERR: err=1, cpu_hold=1, byte_ready=0.
- busy=1 in LEN, DATA, WRITE and CSUM.
- start while busy is ignored. start in DONE or ERR begins a new load; cpu_hold returns to 1 the next cycle.
- byte_valid in IDLE, DONE or ERR is ignored; bytes are not consumed.
- Reset mid-load: immediate return to reset values. Words already written remain in memory; the partial word is discarded.
- The idx multiply uses a shift/add when ADDR_STEP is a power of two. A general constant multiply is acceptable.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last word, state CSUM accepts one extra byte.
  - Expected value is the XOR of every byte of N and all data bytes.
  - Match -> DONE; mismatch -> ERR. All words are still written either way.
  - For N==0, CSUM is still entered and checks the XOR of the 4 length bytes.
- Undefined: no CSUM state; the image ends at the last data byte.

Decomposition:
- Shared package `loader_pkg`: state encoding constants (IDLE, LEN, DATA, WRITE, CSUM, DONE, ERR) and the 32-bit word width.
- One natural sub-module: `byte_packer`, a 4-byte MSB-first shift register with a byte counter and a word_valid pulse, used for both LEN and DATA.

Test Plan:
- BASE_ADDR=0x0F, ADDR_STEP=1; start, bytes 00 00 00 02 FF 00 00 00 00 FF 00 00 -> write pulses at add=0x0F data=0xFF000000, then add=0x10 data=0x00FF0000; done=1; cpu_hold 1->0; words_written=2.
- Length bytes 00 00 00 00 -> DONE with no write pulse; done=1, err=0.
- Length 0x00000101 with MAX_WORDS=256 -> err=1, no writes, byte_ready=0 after the 4th byte, cpu_hold stays 1.
- byte_valid toggled every other cycle with WRITE_CYCLES=3 -> write high exactly 3 cycles per word; byte_ready=0 during each pulse; data identical to the gap-free run.
- rst pulse after 6 of 12 bytes -> all outputs at reset values immediately. A fresh start plus the full stream gives the same result as scenario 1.
- With IMEM_LOADER_CHECKSUM_EN, scenario 1 stream + byte 0x02 -> done=1. Same stream + 0x03 -> err=1, and both writes still occurred.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: word width and
// the loader state encoding.
package loader_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CSUM  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: 4-byte MSB-first shift register. The assembled word and the
// word_valid pulse are presented in the same cycle the 4th byte is taken, so
// the owner can act on the word at that very clock edge.
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              take,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic [1:0]        count
);

  logic [23:0] shift;

  // Shift accepted bytes in and count them; the counter wraps after byte 4.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift <= '0;
      count <= '0;
    end else if (clear) begin
      shift <= '0;
      count <= '0;
    end else if (take) begin
      shift <= {shift[15:0], byte_in};
      count <= count + 2'd1;
    end
  end

  assign word       = {shift, byte_in};
  assign word_valid = take && (count == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian byte stream (4-byte length N followed
// by N data words) into instruction-memory writes at consecutive addresses,
// holding the CPU in reset until the image is complete.
// Optional checksum trailer byte enabled by IMEM_LOADER_CHECKSUM_EN.
//
// Byte handshake: a byte is taken on a rising edge where byte_valid and
// byte_ready are both high; byte_ready is registered and nothing is buffered
// while it is low.
module imem_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          ADDR_STEP    = 1,
  parameter int          MAX_WORDS    = 256,
  parameter int          WRITE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [31:0] add,
  output logic [31:0] data,
  output logic        write,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_hold,
  output logic [15:0] words_written
);

  localparam bit STEP_POW2  = (ADDR_STEP > 0) && ((ADDR_STEP & (ADDR_STEP - 1)) == 0);
  localparam int STEP_SHIFT = $clog2(ADDR_STEP);

  state_t            state;
  logic [31:0]       n_words;
  logic [31:0]       idx;
  logic [3:0]        wcnt;
  logic              take;
  logic              clear;
  logic [WORD_W-1:0] word;
  logic              word_valid;
  logic [1:0]        byte_count;
  logic [31:0]       step_off;
  logic [31:0]       idx_next;
  logic              idle_like;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
`endif

  assign idle_like = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);
  assign clear     = idle_like && start;
  assign take      = byte_valid && byte_ready && ((state == ST_LEN) || (state == ST_DATA));
  assign idx_next  = idx + 32'd1;
  // Power-of-two steps reduce to a shift; other steps use a constant multiply.
  assign step_off  = STEP_POW2 ? (idx << STEP_SHIFT) : (idx * 32'(ADDR_STEP));

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .take       (take),
    .byte_in    (byte_in),
    .word       (word),
    .word_valid (word_valid),
    .count      (byte_count)
  );

  // Loader FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      add           <= '0;
      data          <= '0;
      write         <= 1'b0;
      byte_ready    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      cpu_hold      <= 1'b1;
      words_written <= '0;
      n_words       <= '0;
      idx           <= '0;
      wcnt          <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (take) csum <= csum ^ byte_in;
`endif
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state         <= ST_LEN;
            byte_ready    <= 1'b1;
            busy          <= 1'b1;
            done          <= 1'b0;
            err           <= 1'b0;
            cpu_hold      <= 1'b1;
            words_written <= '0;
            idx           <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum          <= '0;
`endif
          end
        end
        ST_LEN: begin
          if (word_valid) begin
            n_words <= word;
            if (word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state      <= ST_CSUM;
`else
              state      <= ST_DONE;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              cpu_hold   <= 1'b0;
`endif
            end else if (word > 32'(MAX_WORDS)) begin
              state      <= ST_ERR;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
              err        <= 1'b1;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (word_valid) begin
            data       <= word;
            add        <= BASE_ADDR + step_off;
            write      <= 1'b1;
            wcnt       <= '0;
            byte_ready <= 1'b0;
            state      <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (wcnt == 4'(WRITE_CYCLES - 1)) begin
            write         <= 1'b0;
            idx           <= idx_next;
            words_written <= words_written + 16'd1;
            if (idx_next == n_words) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state      <= ST_CSUM;
              byte_ready <= 1'b1;
`else
              state      <= ST_DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              cpu_hold   <= 1'b0;
`endif
            end else begin
              state      <= ST_DATA;
              byte_ready <= 1'b1;
            end
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (byte_valid && byte_ready) begin
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            if (byte_in == csum) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ST_ERR;
              err   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state      <= ST_IDLE;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
          write      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: randomized and directed byte streams, a
// stream-level reference model filling an expected-write queue, and a
// monitor that checks every write pulse against that queue.
module tb_imem_loader;

  localparam logic [31:0] BASE_ADDR    = 32'h0000_000F;
  localparam int          ADDR_STEP    = 1;
  localparam int          MAX_WORDS    = 256;
  localparam int          WRITE_CYCLES = 3;
  localparam int          WAIT_LIMIT   = 200;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] add;
  logic [31:0] data;
  logic        write;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_hold;
  logic [15:0] words_written;

  imem_loader #(
    .BASE_ADDR    (BASE_ADDR),
    .ADDR_STEP    (ADDR_STEP),
    .MAX_WORDS    (MAX_WORDS),
    .WRITE_CYCLES (WRITE_CYCLES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .add           (add),
    .data          (data),
    .write         (write),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .cpu_hold      (cpu_hold),
    .words_written (words_written)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          tests = 0;
  int          fails = 0;
  logic [63:0] exp_q[$];     // {add, data} per expected write
  logic [7:0]  stream_q[$];  // bytes of the load being driven
  bit          exp_done;
  bit          exp_err;
  int          exp_ww;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  // Derives expected writes and final status from the byte stream alone.
  task automatic build_model(input bit bad_csum);
    logic [31:0] n;
    logic [31:0] w;
    logic [7:0]  x;
    n = {stream_q[0], stream_q[1], stream_q[2], stream_q[3]};
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_ww   = 0;
    x        = bad_csum ? 8'h00 : 8'h00;
    if (n > 32'(MAX_WORDS)) begin
      exp_err = 1'b1;
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        w = {stream_q[4+4*i], stream_q[5+4*i], stream_q[6+4*i], stream_q[7+4*i]};
        exp_q.push_back({BASE_ADDR + 32'(i) * 32'(ADDR_STEP), w});
      end
      exp_ww   = int'(n);
      exp_done = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      foreach (stream_q[k]) x = x ^ stream_q[k];
      stream_q.push_back(bad_csum ? (x ^ 8'h01) : x);
      exp_done = !bad_csum;
      exp_err  = bad_csum;
`endif
    end
  endtask

  task automatic make_random_stream(input int n);
    stream_q.delete();
    stream_q.push_back(8'(n >> 24));
    stream_q.push_back(8'(n >> 16));
    stream_q.push_back(8'(n >> 8));
    stream_q.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) stream_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    n          = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= WAIT_LIMIT) check("byte_accept_timeout", 64'(n), 64'(WAIT_LIMIT - 1));
    @(negedge clk);
    byte_valid = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic wait_end_and_check(input string tag);
    int n;
    n = 0;
    while (!(done || err) && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_end_reached"}, 64'(done | err), 64'd1);
    @(negedge clk);
    check({tag, "_done"}, 64'(done), 64'(exp_done));
    check({tag, "_err"}, 64'(err), 64'(exp_err));
    check({tag, "_cpu_hold"}, 64'(cpu_hold), 64'(!exp_done));
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
    check({tag, "_words_written"}, 64'(words_written), 64'(exp_ww));
    check({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Full load of stream_q: model, start, drive, final checks.
  task automatic run_load(input string tag, input bit gap, input bit bad_csum, input int start_at);
    build_model(bad_csum);
    pulse_start();
    check({tag, "_hold_after_start"}, 64'(cpu_hold), 64'd1);
    check({tag, "_busy_after_start"}, 64'(busy), 64'd1);
    check({tag, "_done_cleared"}, 64'(done), 64'd0);
    check({tag, "_ww_cleared"}, 64'(words_written), 64'd0);
    foreach (stream_q[i]) begin
      if (i == start_at) pulse_start();
      send_byte(stream_q[i], gap);
    end
    if (!gap) check({tag, "_ready_after_last"}, 64'(byte_ready), 64'd0);
    wait_end_and_check(tag);
  endtask

  // ---------------- monitor ----------------
  int          run_len = 0;
  logic [63:0] cur_exp = '0;

  always @(negedge clk) begin
    if (rst) begin
      run_len = 0;
    end else if (write) begin
      run_len++;
      check("write_byte_ready_low", 64'(byte_ready), 64'd0);
      if (run_len == 1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {add, data}, 64'd0 - 64'd1);
          cur_exp = {add, data};
        end else begin
          cur_exp = exp_q.pop_front();
          check("write_add", 64'(add), 64'(cur_exp[63:32]));
          check("write_data", 64'(data), 64'(cur_exp[31:0]));
        end
      end else begin
        check("write_stable", {add, data}, cur_exp);
      end
    end else if (run_len != 0) begin
      check("write_pulse_len", 64'(run_len), 64'(WRITE_CYCLES));
      run_len = 0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    #12;
    check("rst_add", 64'(add), 64'd0);
    check("rst_data", 64'(data), 64'd0);
    check("rst_write", 64'(write), 64'd0);
    check("rst_byte_ready", 64'(byte_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_cpu_hold", 64'(cpu_hold), 64'd1);
    check("rst_ww", 64'(words_written), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Bytes offered in IDLE are not accepted.
    byte_in    = 8'hAA;
    byte_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_byte_ready", 64'(byte_ready), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
    end
    byte_valid = 1'b0;

    // Two-word image, gap-free.
    stream_q = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hFF, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'hFF, 8'h00, 8'h00};
    run_load("two_words", 1'b0, 1'b0, -1);

    // Bytes offered in DONE are ignored and status holds.
    byte_in    = 8'h55;
    byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    check("done_ignore_ready", 64'(byte_ready), 64'd0);
    check("done_ignore_ww", 64'(words_written), 64'd2);
    check("done_ignore_done", 64'(done), 64'(exp_done));

    // Zero-length image.
    stream_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_load("zero_len", 1'b0, 1'b0, -1);

    // Length just above the maximum.
    stream_q = '{8'h00, 8'h00, 8'h01, 8'h01};
    run_load("too_long", 1'b0, 1'b0, -1);

    // Same two-word image with byte_valid idle every other cycle.
    stream_q = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hFF, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'hFF, 8'h00, 8'h00};
    run_load("two_words_gap", 1'b1, 1'b0, -1);

    // Reset after 6 of 12 bytes, then a fresh full load.
    stream_q = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hFF, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'hFF, 8'h00, 8'h00};
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(stream_q[i], 1'b0);
    #2 rst = 1'b1;
    #1;
    check("midrst_add", 64'(add), 64'd0);
    check("midrst_data", 64'(data), 64'd0);
    check("midrst_write", 64'(write), 64'd0);
    check("midrst_byte_ready", 64'(byte_ready), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_err", 64'(err), 64'd0);
    check("midrst_cpu_hold", 64'(cpu_hold), 64'd1);
    check("midrst_ww", 64'(words_written), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_load("after_rst", 1'b0, 1'b0, -1);

    // Random images, random pacing, one with a start pulse mid-load.
    for (int t = 0; t < 8; t++) begin
      make_random_stream($urandom_range(1, 6));
      run_load("random", 1'($urandom_range(0, 1)), 1'b0, (t == 3) ? 6 : -1);
    end

    // Largest accepted image.
    make_random_stream(MAX_WORDS);
    run_load("max_words", 1'b0, 1'b0, -1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong trailer byte: writes still happen, load ends in error.
    stream_q = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hFF, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'hFF, 8'h00, 8'h00};
    run_load("bad_csum", 1'b0, 1'b1, -1);
    make_random_stream(3);
    run_load("bad_csum_rand", 1'b1, 1'b1, -1);
`endif

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
